// File: rtl/fp_mul_result_stage.sv
// Registered FP32 multiplier result stage: IEEE fix-up, small FIFO and sticky exception flags.
// Fix-up of out-of-range results is enabled by defining FPMUL_SATURATE_EN.
module fp_mul_result_stage #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   result,
  input  logic          Overflow,
  input  logic          Underflow,
  input  logic          Exception,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [2:0]    out_flags,
  output logic [CW-1:0] count,
  output logic [2:0]    sticky_flags,
  input  logic          flag_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [31:0]   mem_data_q  [DEPTH];
  logic [2:0]    mem_flags_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    sticky_q, sticky_d;

  logic          accept;
  logic          pop;
  logic [2:0]    in_flags;
  logic [31:0]   fixed_data;

  assign in_flags  = {Exception, Overflow, Underflow};
  assign in_ready  = (count_q != FullCount) & ~rst;
  // Gated by rst so no beat is handed out during the reset cycle.
  assign out_valid = (count_q != '0) & ~rst;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_data     = mem_data_q[rd_ptr_q];
  assign out_flags    = mem_flags_q[rd_ptr_q];
  assign count        = count_q;
  assign sticky_flags = sticky_q;

`ifdef FPMUL_SATURATE_EN
  always_comb begin
    fixed_data = result;
    if (Exception) begin
      fixed_data = 32'h7FC0_0000;
    end else if (Overflow) begin
      fixed_data = {result[31], 8'hFF, 23'h0};
    end else if (Underflow) begin
      fixed_data = {result[31], 31'h0};
    end
  end
`else
  assign fixed_data = result;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Set wins over clear when both happen in one cycle.
    sticky_d = (flag_clr ? 3'b000 : sticky_q) | (accept ? in_flags : 3'b000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sticky_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_data_q[wr_ptr_q]  <= fixed_data;
      mem_flags_q[wr_ptr_q] <= in_flags;
    end
  end

endmodule

// File: tb/tb_fp_mul_result_stage.sv
// Self-checking bench for fp_mul_result_stage: vector table, directed corner sequences and
// a randomized run against a queue-based reference model.
module tb_fp_mul_result_stage;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   result;
  logic          Overflow, Underflow, Exception;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [2:0]    out_flags;
  logic [CW-1:0] count;
  logic [2:0]    sticky_flags;
  logic          flag_clr;

  int checks = 0;
  int errors = 0;

  fp_mul_result_stage #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .result(result),
    .Overflow(Overflow), .Underflow(Underflow), .Exception(Exception),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flags(out_flags), .count(count), .sticky_flags(sticky_flags), .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flags;    // {exc, ovf, unf}
    logic [31:0] exp_sat;  // expected data with fix-up enabled
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  f;
  } ent_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_fix(input logic [31:0] r, input logic [2:0] f);
`ifdef FPMUL_SATURATE_EN
    if (f[2]) return 32'h7FC0_0000;
    if (f[1]) return r[31] ? 32'hFF80_0000 : 32'h7F80_0000;
    if (f[0]) return r[31] ? 32'h8000_0000 : 32'h0000_0000;
`endif
    return r;
  endfunction

  task automatic drive_beat(input logic v, input logic [31:0] r, input logic [2:0] f);
    in_valid  = v;
    result    = r;
    Exception = f[2];
    Overflow  = f[1];
    Underflow = f[0];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_beat(1'b0, 32'h0, 3'b000);
    out_ready = 1'b0;
    flag_clr  = 1'b0;
    @(negedge clk);
    chk("in_ready_in_reset", {31'h0, in_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", {31'h0, in_ready}, 32'h1);
    chk("count_after_reset", {29'h0, count}, 32'h0);
    chk("out_valid_after_reset", {31'h0, out_valid}, 32'h0);
    chk("sticky_after_reset", {29'h0, sticky_flags}, 32'h0);
  endtask

  vec_t vecs[7];
  ent_t q[$];
  logic [2:0] sticky_m;

  initial begin
    vecs[0] = '{32'h3F80_0000, 3'b000, 32'h3F80_0000};
    vecs[1] = '{32'h8012_3456, 3'b010, 32'hFF80_0000};
    vecs[2] = '{32'h0040_0000, 3'b001, 32'h0000_0000};
    vecs[3] = '{32'h1234_5678, 3'b100, 32'h7FC0_0000};
    vecs[4] = '{32'h0000_0001, 3'b011, 32'h7F80_0000};
    vecs[5] = '{32'hC000_0000, 3'b110, 32'h7FC0_0000};
    vecs[6] = '{32'h8000_0005, 3'b001, 32'h8000_0000};

    do_reset();

    // Vector table: one beat in, check it at the head one cycle later.
    foreach (vecs[i]) begin
      logic [31:0] exp_d;
`ifdef FPMUL_SATURATE_EN
      exp_d = vecs[i].exp_sat;
`else
      exp_d = vecs[i].res;
`endif
      out_ready = 1'b1;
      drive_beat(1'b1, vecs[i].res, vecs[i].flags);
      @(negedge clk);
      drive_beat(1'b0, 32'h0, 3'b000);
      chk($sformatf("vec%0d_valid", i), {31'h0, out_valid}, 32'h1);
      chk($sformatf("vec%0d_data", i), out_data, exp_d);
      chk($sformatf("vec%0d_flags", i), {29'h0, out_flags}, {29'h0, vecs[i].flags});
      chk($sformatf("vec%0d_count", i), {29'h0, count}, 32'h1);
      @(negedge clk);
      chk($sformatf("vec%0d_drained", i), {29'h0, count}, 32'h0);
    end

    // Fill to full with the consumer stalled, then drain in order.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive_beat(1'b1, 32'(i), 3'b000);
      @(negedge clk);
    end
    chk("full_count", {29'h0, count}, 32'h4);
    chk("full_in_ready", {31'h0, in_ready}, 32'h0);
    drive_beat(1'b1, 32'h5, 3'b000);
    @(negedge clk);
    chk("full_no_accept", {29'h0, count}, 32'h4);
    chk("stall_data_stable", out_data, 32'h1);
    drive_beat(1'b0, 32'h0, 3'b000);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain%0d_data", i), out_data, 32'(i));
      @(negedge clk);
      if (i == 1) chk("in_ready_after_pop", {31'h0, in_ready}, 32'h1);
    end
    chk("drain_empty", {31'h0, out_valid}, 32'h0);

    // Simultaneous accept and pop at count 2 across pointer wrap.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive_beat(1'b1, 32'h10 + 32'(i), 3'b000);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive_beat(1'b1, 32'h12 + 32'(k), 3'b000);
      chk($sformatf("thru%0d_head", k), out_data, 32'h10 + 32'(k));
      @(negedge clk);
      chk($sformatf("thru%0d_count", k), {29'h0, count}, 32'h2);
    end
    drive_beat(1'b0, 32'h0, 3'b000);
    chk("thru_head_after", out_data, 32'h16);

    // Sticky flags: set, then clear together with a new set.
    do_reset();
    out_ready = 1'b1;
    drive_beat(1'b1, 32'h7F00_0000, 3'b010);
    @(negedge clk);
    drive_beat(1'b0, 32'h0, 3'b000);
    @(negedge clk);
    chk("sticky_ovf", {29'h0, sticky_flags}, 32'h2);
    flag_clr = 1'b1;
    drive_beat(1'b1, 32'h0000_0001, 3'b001);
    @(negedge clk);
    chk("sticky_clr_set", {29'h0, sticky_flags}, 32'h1);
    drive_beat(1'b0, 32'h0, 3'b000);
    @(negedge clk);
    chk("sticky_clr", {29'h0, sticky_flags}, 32'h0);
    flag_clr = 1'b0;

    // Reset with entries queued discards them and clears sticky flags.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_beat(1'b1, 32'h20 + 32'(i), 3'b100);
      @(negedge clk);
    end
    chk("pre_reset_count", {29'h0, count}, 32'h3);
    chk("pre_reset_sticky", {29'h0, sticky_flags}, 32'h4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_beat(1'b0, 32'h0, 3'b000);
    #1;
    chk("post_reset_count", {29'h0, count}, 32'h0);
    chk("post_reset_valid", {31'h0, out_valid}, 32'h0);
    chk("post_reset_sticky", {29'h0, sticky_flags}, 32'h0);
    drive_beat(1'b1, 32'hABCD, 3'b000);
    @(negedge clk);
    drive_beat(1'b0, 32'h0, 3'b000);
    chk("post_reset_head", out_data, 32'hABCD);
    chk("post_reset_count1", {29'h0, count}, 32'h1);

    // Randomized run against the queue model.
    do_reset();
    q.delete();
    sticky_m = 3'b000;
    for (int c = 0; c < 600; c++) begin
      logic       acc, pp;
      logic [2:0] f;
      @(negedge clk);
      if (rst) begin
        chk("rnd_in_ready_rst", {31'h0, in_ready}, 32'h0);
      end else begin
        chk("rnd_count", {29'h0, count}, 32'(q.size()));
        chk("rnd_valid", {31'h0, out_valid}, {31'h0, q.size() != 0});
        chk("rnd_in_ready", {31'h0, in_ready}, {31'h0, q.size() < DEPTH});
        chk("rnd_sticky", {29'h0, sticky_flags}, {29'h0, sticky_m});
        if (q.size() != 0) begin
          chk("rnd_data", out_data, q[0].d);
          chk("rnd_flags", {29'h0, out_flags}, {29'h0, q[0].f});
        end
      end
      rst       = ($urandom_range(0, 59) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flag_clr  = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 5))
        0:       f = 3'b100;
        1:       f = 3'b010;
        2:       f = 3'b001;
        3:       f = 3'(($urandom_range(0, 7)));
        default: f = 3'b000;
      endcase
      drive_beat($urandom_range(0, 3) != 0, $urandom, f);
      acc = in_valid && !rst && (q.size() < DEPTH);
      pp  = out_ready && !rst && (q.size() != 0);
      if (rst) begin
        q.delete();
        sticky_m = 3'b000;
      end else begin
        if (pp) void'(q.pop_front());
        if (acc) q.push_back('{model_fix(result, f), f});
        sticky_m = (flag_clr ? 3'b000 : sticky_m) | (acc ? f : 3'b000);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
